// File: rtl/program_memory_loader.sv
// Run-time loadable instruction memory: assembles a little-endian byte stream
// into instruction words, then serves registered fetches while releasing the CPU.
module program_memory_loader #(
  parameter int                    DATA_WIDTH   = 30,
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DEPTH        = 256,
  parameter int                    BYTE_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = '0,
  localparam int                   BPW          = (DATA_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH,
  localparam int                   CW           = $clog2(DEPTH + 1)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iLoadStart,
  input  logic [BYTE_WIDTH-1:0] iByte,
  input  logic                  iByteValid,
  input  logic                  iLoadDone,
  input  logic [ADDR_WIDTH-1:0] iAddress,
  output logic [DATA_WIDTH-1:0] oInstruction,
  output logic                  oCpuHold,
  output logic                  oLoading,
  output logic [CW-1:0]         oWordCount
);

  localparam int BCW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int RAW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ASW  = BPW * BYTE_WIDTH;
  localparam int CMPW = (ADDR_WIDTH > CW) ? ADDR_WIDTH : CW;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           count, count_n;
  logic [BCW-1:0]          byte_cnt, byte_cnt_n;
  logic [ASW-1:0]          asm_q, asm_n, asm_upd;
  logic                    hold_n;
  logic                    word_full, flush, wr_en, in_range;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign oWordCount = count;
  assign oLoading   = (state == LOAD);
  assign in_range   = CMPW'(iAddress) < CMPW'(count);

  always_comb begin
    state_n    = state;
    count_n    = count;
    byte_cnt_n = byte_cnt;
    asm_n      = asm_q;
    wr_en      = 1'b0;
    asm_upd    = asm_q;
    for (int i = 0; i < BPW; i++)
      if (iByteValid && byte_cnt == BCW'(i)) asm_upd[i*BYTE_WIDTH +: BYTE_WIDTH] = iByte;
    // A done pulse flushes whatever the word holds after this cycle's byte,
    // so a byte that completes the word plus done still writes exactly once.
    word_full = iByteValid && (byte_cnt == BCW'(BPW - 1));
    flush     = word_full || (iLoadDone && (iByteValid || byte_cnt != '0));
    wr_data   = asm_upd[DATA_WIDTH-1:0];

    case (state)
      IDLE: if (iLoadStart) begin
        state_n    = LOAD;
        count_n    = '0;
        byte_cnt_n = '0;
        asm_n      = '0;
      end
      LOAD: begin
        if (iLoadStart) begin
          count_n    = '0;
          byte_cnt_n = '0;
          asm_n      = '0;
        end else if (flush) begin
          wr_en      = 1'b1;
          count_n    = count + CW'(1);
          byte_cnt_n = '0;
          asm_n      = '0;
          if (iLoadDone || count_n == CW'(DEPTH)) state_n = RUN;
        end else begin
          if (iByteValid) begin
            byte_cnt_n = byte_cnt + BCW'(1);
            asm_n      = asm_upd;
          end
          if (iLoadDone) state_n = RUN;
        end
      end
      RUN: if (iLoadStart) begin
        state_n    = LOAD;
        count_n    = '0;
        byte_cnt_n = '0;
        asm_n      = '0;
      end
      default: state_n = IDLE;
    endcase

    // Release only once RUN has been held for a full cycle; re-hold on the leaving edge.
    hold_n = (state != RUN) || (state_n != RUN);
  end

  always_ff @(posedge Clock) begin
    if (wr_en) mem[count[RAW-1:0]] <= wr_data;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      count        <= '0;
      byte_cnt     <= '0;
      asm_q        <= '0;
      oCpuHold     <= 1'b1;
      oInstruction <= DEFAULT_WORD;
    end else begin
      state        <= state_n;
      count        <= count_n;
      byte_cnt     <= byte_cnt_n;
      asm_q        <= asm_n;
      oCpuHold     <= hold_n;
      oInstruction <= (state == RUN && in_range) ? mem[iAddress[RAW-1:0]] : DEFAULT_WORD;
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// Randomized bench for program_memory_loader: default-size instance plus a DEPTH=4
// instance, checked against a byte-queue model of the load stream.
module tb_program_memory_loader;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        start, bval, done;
  logic [7:0]  bdat;
  logic [15:0] addr;
  logic [29:0] instr;
  logic        hold, loading;
  logic [8:0]  wcount;

  logic        s_start, s_bval, s_done;
  logic [7:0]  s_bdat;
  logic [7:0]  s_addr;
  logic [29:0] s_instr;
  logic        s_hold, s_loading;
  logic [2:0]  s_wcount;

  localparam logic [29:0] S_DEF = 30'h155;

  int errors = 0;
  int checks = 0;
  logic [7:0] mq[$];
  logic [7:0] sq[$];

  always #5 Clock = ~Clock;

  program_memory_loader dut (
    .Clock(Clock), .Reset(Reset), .iLoadStart(start), .iByte(bdat), .iByteValid(bval),
    .iLoadDone(done), .iAddress(addr), .oInstruction(instr), .oCpuHold(hold),
    .oLoading(loading), .oWordCount(wcount)
  );

  program_memory_loader #(.ADDR_WIDTH(8), .DEPTH(4), .DEFAULT_WORD(S_DEF)) dut_s (
    .Clock(Clock), .Reset(Reset), .iLoadStart(s_start), .iByte(s_bdat), .iByteValid(s_bval),
    .iLoadDone(s_done), .iAddress(s_addr), .oInstruction(s_instr), .oCpuHold(s_hold),
    .oLoading(s_loading), .oWordCount(s_wcount)
  );

  // Word w of a stream: bytes 4w..4w+3 little-endian, missing bytes zero, top bits dropped.
  function automatic logic [29:0] pack_word(input logic [7:0] q[$], input int w);
    logic [31:0] v = '0;
    for (int b = 0; b < 4; b++)
      if (w * 4 + b < q.size()) v[b*8 +: 8] = q[w*4+b];
    return v[29:0];
  endfunction

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic send(input logic [7:0] b, input logic d);
    bval = 1'b1; bdat = b; done = d;
    tick();
    bval = 1'b0; done = 1'b0; bdat = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1; tick(); done = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] a;
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b want 1", hold); end
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL reset_loading: got %b want 0", loading); end
    checks++; if (wcount !== 9'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", wcount); end
    checks++; if (s_instr !== S_DEF) begin errors++; $display("FAIL reset_small_instr: got %h want %h", s_instr, S_DEF); end
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); addr = a; tick();
      checks++; if (instr !== 30'h0) begin errors++; $display("FAIL idle_fetch a=%h: got %h want 0", a, instr); end
    end
    send(8'($urandom), 1'b0);
    send(8'($urandom), 1'b1);
    checks++; if (wcount !== 9'd0 || hold !== 1'b1 || loading !== 1'b0) begin
      errors++; $display("FAIL idle_ignore: count=%0d hold=%b loading=%b want 0/1/0", wcount, hold, loading);
    end
  endtask

  task automatic test_basic();
    pulse_start();
    checks++; if (loading !== 1'b1 || hold !== 1'b1) begin
      errors++; $display("FAIL load_entry: loading=%b hold=%b want 1/1", loading, hold);
    end
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    pulse_done();
    checks++; if (wcount !== 9'd2) begin errors++; $display("FAIL basic_count: got %0d want 2", wcount); end
    checks++; if (loading !== 1'b0 || hold !== 1'b1) begin
      errors++; $display("FAIL run_entry: loading=%b hold=%b want 0/1", loading, hold);
    end
    tick();
    checks++; if (hold !== 1'b0) begin errors++; $display("FAIL run_release: hold=%b want 0", hold); end
    addr = 16'd1; tick();
    checks++; if (instr !== 30'h08070605) begin errors++; $display("FAIL basic_w1: got %h want 08070605", instr); end
    addr = 16'd0; tick();
    checks++; if (instr !== 30'h04030201) begin errors++; $display("FAIL basic_w0: got %h want 04030201", instr); end
    addr = 16'd2; tick();
    checks++; if (instr !== 30'h0) begin errors++; $display("FAIL basic_w2: got %h want 0", instr); end
  endtask

  task automatic test_same_cycle();
    pulse_start();
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL restart_hold: got %b want 1", hold); end
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
    checks++; if (wcount !== 9'd1 || loading !== 1'b0) begin
      errors++; $display("FAIL same_cycle_count: count=%0d loading=%b want 1/0", wcount, loading);
    end
    addr = 16'd0; tick();
    checks++; if (instr !== 30'h00CCBBAA) begin errors++; $display("FAIL same_cycle_w0: got %h want 00CCBBAA", instr); end
    addr = 16'd1; tick();
    checks++; if (instr !== 30'h0) begin errors++; $display("FAIL same_cycle_w1: got %h want 0", instr); end
  endtask

  task automatic test_random();
    int n, exp_cnt, a;
    logic combine;
    logic [7:0] b;
    logic [29:0] exp_w;
    for (int r = 0; r < 5; r++) begin
      mq.delete();
      pulse_start();
      n = $urandom_range(1, 40);
      combine = 1'($urandom);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        b = 8'($urandom);
        mq.push_back(b);
        send(b, combine && (i == n - 1));
      end
      if (!combine) pulse_done();
      exp_cnt = (n + 3) / 4;
      checks++; if (wcount !== 9'(exp_cnt) || loading !== 1'b0) begin
        errors++; $display("FAIL rand%0d_count: count=%0d loading=%b want %0d/0", r, wcount, loading, exp_cnt);
      end
      tick();
      for (int k = 0; k < 8; k++) begin
        a = (k == 7) ? 16'hFFFF : $urandom_range(0, exp_cnt + 2);
        addr = 16'(a); tick();
        exp_w = (a < exp_cnt) ? pack_word(mq, a) : 30'h0;
        checks++; if (instr !== exp_w || hold !== 1'b0) begin
          errors++; $display("FAIL rand%0d_fetch a=%0d: got %h hold=%b want %h hold=0", r, a, instr, hold, exp_w);
        end
      end
    end
  endtask

  task automatic test_restart();
    logic [7:0] b;
    pulse_start();
    for (int i = 0; i < 6; i++) send(8'($urandom), 1'b0);
    checks++; if (wcount !== 9'd1) begin errors++; $display("FAIL restart_pre_count: got %0d want 1", wcount); end
    start = 1'b1; bval = 1'b1; bdat = 8'hEE; done = 1'b1;
    tick();
    start = 1'b0; bval = 1'b0; done = 1'b0;
    checks++; if (wcount !== 9'd0 || loading !== 1'b1) begin
      errors++; $display("FAIL restart_clear: count=%0d loading=%b want 0/1", wcount, loading);
    end
    mq.delete();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom); mq.push_back(b); send(b, 1'b0);
    end
    pulse_done();
    checks++; if (wcount !== 9'd1) begin errors++; $display("FAIL restart_count: got %0d want 1", wcount); end
    addr = 16'd0; tick();
    checks++; if (instr !== pack_word(mq, 0)) begin
      errors++; $display("FAIL restart_w0: got %h want %h", instr, pack_word(mq, 0));
    end
    addr = 16'd1; tick();
    checks++; if (instr !== 30'h0) begin errors++; $display("FAIL restart_w1: got %h want 0", instr); end
  endtask

  task automatic test_auto_end();
    logic [29:0] exp_w;
    sq.delete();
    s_start = 1'b1; tick(); s_start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      s_bval = 1'b1; s_bdat = 8'($urandom); sq.push_back(s_bdat);
      tick();
      s_bval = 1'b0;
      if (i == 15) begin
        checks++; if (s_loading !== 1'b1 || s_wcount !== 3'd3) begin
          errors++; $display("FAIL auto_pre: loading=%b count=%0d want 1/3", s_loading, s_wcount);
        end
      end
    end
    checks++; if (s_loading !== 1'b0 || s_wcount !== 3'd4) begin
      errors++; $display("FAIL auto_end: loading=%b count=%0d want 0/4", s_loading, s_wcount);
    end
    s_bval = 1'b1; s_bdat = 8'h99; s_done = 1'b1; tick(); s_bval = 1'b0; s_done = 1'b0;
    checks++; if (s_wcount !== 3'd4) begin errors++; $display("FAIL auto_extra: count=%0d want 4", s_wcount); end
    for (int a = 4; a >= 0; a--) begin
      s_addr = 8'(a); tick();
      exp_w = (a < 4) ? pack_word(sq, a) : S_DEF;
      checks++; if (s_instr !== exp_w) begin
        errors++; $display("FAIL auto_fetch a=%0d: got %h want %h", a, s_instr, exp_w);
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_start();
    for (int i = 0; i < 6; i++) send(8'($urandom), 1'b0);
    checks++; if (wcount !== 9'd1 || s_hold !== 1'b0) begin
      errors++; $display("FAIL areset_pre: count=%0d s_hold=%b want 1/0", wcount, s_hold);
    end
    @(negedge Clock); #1;
    Reset = 1'b1;
    #1;
    checks++; if (hold !== 1'b1 || loading !== 1'b0 || wcount !== 9'd0) begin
      errors++; $display("FAIL areset_main: hold=%b loading=%b count=%0d want 1/0/0", hold, loading, wcount);
    end
    checks++; if (s_instr !== S_DEF || s_hold !== 1'b1 || s_wcount !== 3'd0) begin
      errors++; $display("FAIL areset_small: instr=%h hold=%b count=%0d want %h/1/0", s_instr, s_hold, s_wcount, S_DEF);
    end
    tick();
    Reset = 1'b0;
    addr = 16'd0; tick();
    checks++; if (instr !== 30'h0 || hold !== 1'b1) begin
      errors++; $display("FAIL post_reset_fetch: instr=%h hold=%b want 0/1", instr, hold);
    end
    pulse_start();
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    tick();
    checks++; if (instr !== 30'h0 || hold !== 1'b1 || wcount !== 9'd1) begin
      errors++; $display("FAIL reload_pending: instr=%h hold=%b count=%0d want 0/1/1", instr, hold, wcount);
    end
    pulse_done();
    tick();
    tick();
    checks++; if (instr !== 30'h04332211 || hold !== 1'b0) begin
      errors++; $display("FAIL reload_fetch: instr=%h hold=%b want 04332211/0", instr, hold);
    end
  endtask

  initial begin
    Reset = 1'b1;
    start = 1'b0; bval = 1'b0; done = 1'b0; bdat = 8'h0; addr = 16'h0;
    s_start = 1'b0; s_bval = 1'b0; s_done = 1'b0; s_bdat = 8'h0; s_addr = 8'h0;
    repeat (2) tick();
    Reset = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_same_cycle();
    test_random();
    test_restart();
    test_auto_end();
    s_addr = 8'd0; tick();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
